// File: rtl/window_minmax_tracker_pkg.sv
// Shared definitions for the window min/max tracker.
//   SAMPLE_W : width of one input sample
//   state_t  : control FSM encoding (IDLE / ACCUM / REPORT)
package window_minmax_tracker_pkg;

    localparam int SAMPLE_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_t;

endpackage

// File: rtl/window_minmax_tracker_comparator.sv
// 4-bit unsigned magnitude comparator with bit-level ports.
// Ports:
//   a0..a3   : operand A, a0 is the LSB
//   b0..b3   : operand B, b0 is the LSB
//   a_bigger : A > B
//   b_bigger : B > A
//   equals   : A == B
module comparator (
    input  logic a0,
    input  logic a1,
    input  logic a2,
    input  logic a3,
    input  logic b0,
    input  logic b1,
    input  logic b2,
    input  logic b3,
    output logic a_bigger,
    output logic b_bigger,
    output logic equals
);

    logic [3:0] a_vec;
    logic [3:0] b_vec;

    assign a_vec    = {a3, a2, a1, a0};
    assign b_vec    = {b3, b2, b1, b0};
    assign a_bigger = (a_vec > b_vec);
    assign b_bigger = (b_vec > a_vec);
    assign equals   = (a_vec == b_vec);

endmodule

// File: rtl/window_minmax_tracker.sv
// Windowed min/max/repeat tracker.
// Accepts WIN_LEN samples over a valid/ready handshake, tracks the running
// maximum, the running minimum and the number of samples equal to their
// immediate predecessor, then presents one result word over a valid/ready
// output handshake before starting a fresh window.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   in_valid    : in_data holds a sample
//   in_ready    : a sample can be accepted this cycle (low while reporting)
//   in_data     : unsigned sample
//   out_valid   : result word is valid
//   out_ready   : downstream takes the result
//   out_max     : window maximum
//   out_min     : window minimum
//   out_eq_cnt  : samples equal to the previous sample of the same window
module window_minmax_tracker
    import window_minmax_tracker_pkg::*;
#(
    parameter int WIN_LEN = 8,
    parameter int CNT_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SAMPLE_W-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SAMPLE_W-1:0] out_max,
    output logic [SAMPLE_W-1:0] out_min,
    output logic [CNT_W-1:0]    out_eq_cnt
);

    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_LEN);

    state_t              state_q, state_d;
    logic [SAMPLE_W-1:0] max_q, max_d;
    logic [SAMPLE_W-1:0] min_q, min_d;
    logic [SAMPLE_W-1:0] prev_q, prev_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    eq_q, eq_d;

    logic accept;

    // Comparator bank: index 0 = max, 1 = min, 2 = prev; A is always in_data.
    logic [SAMPLE_W-1:0] cmp_b [3];
    logic [2:0]          cmp_gt;
    logic [2:0]          cmp_lt;
    logic [2:0]          cmp_eq;

    assign cmp_b[0] = max_q;
    assign cmp_b[1] = min_q;
    assign cmp_b[2] = prev_q;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cmp
            comparator u_cmp (
                .a0       (in_data[0]),
                .a1       (in_data[1]),
                .a2       (in_data[2]),
                .a3       (in_data[3]),
                .b0       (cmp_b[gi][0]),
                .b1       (cmp_b[gi][1]),
                .b2       (cmp_b[gi][2]),
                .b3       (cmp_b[gi][3]),
                .a_bigger (cmp_gt[gi]),
                .b_bigger (cmp_lt[gi]),
                .equals   (cmp_eq[gi])
            );
        end
    endgenerate

    // Each comparator only contributes one flag; the rest are intentionally dropped.
    logic unused_cmp_flags;
    assign unused_cmp_flags = &{1'b0, cmp_gt[2:1], cmp_lt[2], cmp_lt[0], cmp_eq[1:0]};

    assign in_ready  = (state_q != REPORT);
    assign out_valid = (state_q == REPORT);
    assign accept    = in_valid && in_ready;

    assign out_max    = max_q;
    assign out_min    = min_q;
    assign out_eq_cnt = eq_q;

    always_comb begin
        state_d = state_q;
        max_d   = max_q;
        min_d   = min_q;
        prev_d  = prev_q;
        cnt_d   = cnt_q;
        eq_d    = eq_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    // First sample of a window seeds every tracker.
                    max_d   = in_data;
                    min_d   = in_data;
                    prev_d  = in_data;
                    eq_d    = '0;
                    cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d = (WIN_LEN == 1) ? REPORT : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (cmp_gt[0]) max_d = in_data;
                    if (cmp_lt[1]) min_d = in_data;
                    if (cmp_eq[2]) eq_d  = eq_q + 1'b1;
                    prev_d = in_data;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_d == WIN_LAST) state_d = REPORT;
                end
            end
            REPORT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            max_q   <= '0;
            min_q   <= '0;
            prev_q  <= '0;
            cnt_q   <= '0;
            eq_q    <= '0;
        end else begin
            state_q <= state_d;
            max_q   <= max_d;
            min_q   <= min_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            eq_q    <= eq_d;
        end
    end

endmodule

// File: tb/tb_window_minmax_tracker.sv
// Self-checking bench for window_minmax_tracker.
// Three instances share clk/rst: WIN_LEN=8 (index 0), WIN_LEN=1 (index 1)
// and WIN_LEN=2 (index 2, used to sweep every (prev, sample) pair).
// Inputs change and outputs are sampled on the falling edge of clk.
module tb_window_minmax_tracker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [2:0]      in_valid;
    logic [2:0]      in_ready;
    logic [2:0]      out_valid;
    logic [2:0]      out_ready;
    logic [2:0][3:0] in_data;
    logic [2:0][3:0] out_max;
    logic [2:0][3:0] out_min;
    logic [2:0][3:0] out_eq_cnt;

    int checks   = 0;
    int failures = 0;

    window_minmax_tracker #(.WIN_LEN(8), .CNT_W(4)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_max(out_max[0]), .out_min(out_min[0]), .out_eq_cnt(out_eq_cnt[0])
    );

    window_minmax_tracker #(.WIN_LEN(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_max(out_max[1]), .out_min(out_min[1]), .out_eq_cnt(out_eq_cnt[1])
    );

    window_minmax_tracker #(.WIN_LEN(2), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_max(out_max[2]), .out_min(out_min[2]), .out_eq_cnt(out_eq_cnt[2])
    );

    task automatic tick();
        @(negedge clk);
    endtask

    // Present one sample on instance d and return at the falling edge after it was taken.
    task automatic send(input int d, input logic [3:0] v);
        int guard = 0;
        in_valid[d] = 1'b1;
        in_data[d]  = v;
        while (!in_ready[d] && guard < 40) begin
            tick();
            guard++;
        end
        checks++;
        if (guard >= 40) begin
            failures++;
            $display("FAIL send_timeout dut=%0d in_ready=%b required=1", d, in_ready[d]);
        end
        tick();
        in_valid[d] = 1'b0;
    endtask

    // Reference: fold the accepted samples of one window.
    task automatic model_window(input logic [3:0] q[$], output logic [3:0] mx,
                                output logic [3:0] mn, output logic [3:0] eqc);
        mx  = q[0];
        mn  = q[0];
        eqc = 4'd0;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i] > mx) mx = q[i];
            if (q[i] < mn) mn = q[i];
            if (i > 0 && q[i] == q[i-1]) eqc = eqc + 4'd1;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 3'b111;
        in_data   = {4'd5, 4'd5, 4'd5};
        out_ready = 3'b000;
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({in_ready[d], out_valid[d], out_max[d], out_min[d], out_eq_cnt[d]} !== {1'b1, 1'b0, 12'd0}) begin
                failures++;
                $display("FAIL reset_state dut=%0d got rdy=%b vld=%b max=%0d min=%0d eq=%0d required rdy=1 vld=0 max=0 min=0 eq=0",
                         d, in_ready[d], out_valid[d], out_max[d], out_min[d], out_eq_cnt[d]);
            end
        end
        in_valid = 3'b000;
        rst      = 1'b0;
        tick();
        checks++;
        if (out_valid !== 3'b000) begin
            failures++;
            $display("FAIL reset_release out_valid=%b required=000", out_valid);
        end
    endtask

    task automatic test_basic();
        logic [3:0] s [8] = '{4'd3, 4'd7, 4'd7, 4'd0, 4'd15, 4'd15, 4'd15, 4'd2};
        out_ready[0] = 1'b1;
        for (int i = 0; i < 8; i++) send(0, s[i]);
        checks++;
        if ({out_valid[0], in_ready[0], out_max[0], out_min[0], out_eq_cnt[0]} !== {1'b1, 1'b0, 4'd15, 4'd0, 4'd3}) begin
            failures++;
            $display("FAIL basic_result got vld=%b rdy=%b max=%0d min=%0d eq=%0d required vld=1 rdy=0 max=15 min=0 eq=3",
                     out_valid[0], in_ready[0], out_max[0], out_min[0], out_eq_cnt[0]);
        end
        tick();
        checks++;
        if ({out_valid[0], in_ready[0]} !== 2'b01) begin
            failures++;
            $display("FAIL basic_one_cycle got vld=%b rdy=%b required vld=0 rdy=1", out_valid[0], in_ready[0]);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] s [8] = '{4'd3, 4'd7, 4'd7, 4'd0, 4'd15, 4'd15, 4'd15, 4'd2};
        out_ready[0] = 1'b0;
        for (int i = 0; i < 8; i++) send(0, s[i]);
        // Offer a sample during the stall; it must not be taken.
        in_valid[0] = 1'b1;
        in_data[0]  = 4'd4;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({out_valid[0], in_ready[0], out_max[0], out_min[0], out_eq_cnt[0]} !== {1'b1, 1'b0, 4'd15, 4'd0, 4'd3}) begin
                failures++;
                $display("FAIL backpressure_hold cycle=%0d got vld=%b rdy=%b max=%0d min=%0d eq=%0d required vld=1 rdy=0 max=15 min=0 eq=3",
                         k, out_valid[0], in_ready[0], out_max[0], out_min[0], out_eq_cnt[0]);
            end
            tick();
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        checks++;
        if (out_valid[0] !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_ready_cycle out_valid=%b required=1", out_valid[0]);
        end
        tick();
        checks++;
        if ({out_valid[0], in_ready[0]} !== 2'b01) begin
            failures++;
            $display("FAIL backpressure_idle got vld=%b rdy=%b required vld=0 rdy=1", out_valid[0], in_ready[0]);
        end
    endtask

    task automatic test_gaps_all_equal();
        out_ready[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(0, 4'd9);
            if (i < 7) begin
                tick();
                if (i == 6) begin
                    checks++;
                    if (out_valid[0] !== 1'b0) begin
                        failures++;
                        $display("FAIL gaps_early_report after 7 samples out_valid=%b required=0", out_valid[0]);
                    end
                end
            end
        end
        checks++;
        if ({out_valid[0], out_max[0], out_min[0], out_eq_cnt[0]} !== {1'b1, 4'd9, 4'd9, 4'd7}) begin
            failures++;
            $display("FAIL gaps_result got vld=%b max=%0d min=%0d eq=%0d required vld=1 max=9 min=9 eq=7",
                     out_valid[0], out_max[0], out_min[0], out_eq_cnt[0]);
        end
        tick();
    endtask

    task automatic test_reset_mid_window();
        logic [3:0] s [4] = '{4'd12, 4'd1, 4'd5, 4'd5};
        out_ready[0] = 1'b1;
        for (int i = 0; i < 4; i++) send(0, s[i]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({out_valid[0], in_ready[0], out_max[0], out_min[0], out_eq_cnt[0]} !== {1'b0, 1'b1, 12'd0}) begin
            failures++;
            $display("FAIL midreset_state got vld=%b rdy=%b max=%0d min=%0d eq=%0d required vld=0 rdy=1 max=0 min=0 eq=0",
                     out_valid[0], in_ready[0], out_max[0], out_min[0], out_eq_cnt[0]);
        end
        for (int i = 0; i < 8; i++) send(0, 4'd6);
        checks++;
        if ({out_valid[0], out_max[0], out_min[0], out_eq_cnt[0]} !== {1'b1, 4'd6, 4'd6, 4'd7}) begin
            failures++;
            $display("FAIL midreset_result got vld=%b max=%0d min=%0d eq=%0d required vld=1 max=6 min=6 eq=7",
                     out_valid[0], out_max[0], out_min[0], out_eq_cnt[0]);
        end
        tick();
    endtask

    task automatic test_win1();
        logic [3:0] v;
        out_ready[1] = 1'b1;
        for (int n = 0; n < 6; n++) begin
            v = (n == 0) ? 4'd10 : 4'($urandom_range(0, 15));
            send(1, v);
            checks++;
            if ({out_valid[1], out_max[1], out_min[1], out_eq_cnt[1]} !== {1'b1, v, v, 4'd0}) begin
                failures++;
                $display("FAIL win1_result sample=%0d got vld=%b max=%0d min=%0d eq=%0d required vld=1 max=%0d min=%0d eq=0",
                         v, out_valid[1], out_max[1], out_min[1], out_eq_cnt[1], v, v);
            end
            tick();
            checks++;
            if (out_valid[1] !== 1'b0) begin
                failures++;
                $display("FAIL win1_release out_valid=%b required=0", out_valid[1]);
            end
        end
    endtask

    task automatic test_pairs();
        logic [3:0] p, s, emax, emin, eeq;
        out_ready[2] = 1'b1;
        for (int pi = 0; pi < 16; pi++) begin
            for (int si = 0; si < 16; si++) begin
                p    = 4'(pi);
                s    = 4'(si);
                emax = (pi > si) ? p : s;
                emin = (pi < si) ? p : s;
                eeq  = (pi == si) ? 4'd1 : 4'd0;
                send(2, p);
                send(2, s);
                checks++;
                if ({out_valid[2], out_max[2], out_min[2], out_eq_cnt[2]} !== {1'b1, emax, emin, eeq}) begin
                    failures++;
                    $display("FAIL pair prev=%0d sample=%0d got vld=%b max=%0d min=%0d eq=%0d required vld=1 max=%0d min=%0d eq=%0d",
                             p, s, out_valid[2], out_max[2], out_min[2], out_eq_cnt[2], emax, emin, eeq);
                end
                tick();
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] q[$];
        logic [3:0] v, emax, emin, eeq;
        int hold;
        for (int w = 0; w < 25; w++) begin
            q.delete();
            hold         = int'($urandom_range(0, 3));
            out_ready[0] = (hold == 0);
            for (int i = 0; i < 8; i++) begin
                if (i > 0 && $urandom_range(0, 2) == 0) v = q[i-1];
                else v = 4'($urandom_range(0, 15));
                q.push_back(v);
                send(0, v);
                if (i < 7) repeat ($urandom_range(0, 2)) tick();
            end
            model_window(q, emax, emin, eeq);
            for (int h = 0; h < hold; h++) begin
                checks++;
                if ({out_valid[0], in_ready[0], out_max[0], out_min[0], out_eq_cnt[0]} !== {1'b1, 1'b0, emax, emin, eeq}) begin
                    failures++;
                    $display("FAIL random_hold win=%0d got vld=%b rdy=%b max=%0d min=%0d eq=%0d required vld=1 rdy=0 max=%0d min=%0d eq=%0d",
                             w, out_valid[0], in_ready[0], out_max[0], out_min[0], out_eq_cnt[0], emax, emin, eeq);
                end
                tick();
            end
            out_ready[0] = 1'b1;
            checks++;
            if ({out_valid[0], in_ready[0], out_max[0], out_min[0], out_eq_cnt[0]} !== {1'b1, 1'b0, emax, emin, eeq}) begin
                failures++;
                $display("FAIL random_result win=%0d got vld=%b rdy=%b max=%0d min=%0d eq=%0d required vld=1 rdy=0 max=%0d min=%0d eq=%0d",
                         w, out_valid[0], in_ready[0], out_max[0], out_min[0], out_eq_cnt[0], emax, emin, eeq);
            end
            tick();
            checks++;
            if ({out_valid[0], in_ready[0]} !== 2'b01) begin
                failures++;
                $display("FAIL random_idle win=%0d got vld=%b rdy=%b required vld=0 rdy=1", w, out_valid[0], in_ready[0]);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 3'b000;
        out_ready = 3'b000;
        in_data   = '0;
        tick();
        test_reset();
        test_basic();
        test_backpressure();
        test_gaps_all_equal();
        test_reset_mid_window();
        test_win1();
        test_pairs();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/window_minmax_tracker.md
Name: window_minmax_tracker

Overview:
- Sequential stage directly downstream of the existing 4-bit `comparator`; consumes its a_bigger/b_bigger/equals flags.
- Accepts a stream of 4-bit samples over a valid/ready handshake and tracks, per window of WIN_LEN samples, the running maximum, the running minimum, and the count of samples equal to their immediate predecessor.
- At window end it presents one result word over a valid/ready output handshake, then starts a fresh window.

Parameters:
- WIN_LEN, 8, samples per window; legal range 1..15.
- CNT_W, 4, width of the sample counter and of out_eq_cnt; must hold WIN_LEN.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  4  unsigned sample.
- out_valid  output  1  result word is valid.
- out_ready  input  1  downstream accepts the result.
- out_max  output  4  window maximum.
- out_min  output  4  window minimum.
- out_eq_cnt  output  CNT_W  count of samples equal to the previous sample in the same window.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_max=0, out_min=0, out_eq_cnt=0, internal count=0, prev=0.
- Accept rule: a sample is accepted on any rising edge with in_valid && in_ready. The result is handed off on any edge with out_valid && out_ready.
- FSM states:
  - IDLE: in_ready=1. On accept, load max=min=prev=in_data, eq_cnt=0, count=1. If WIN_LEN==1, go to REPORT; otherwise go to ACCUM.
  - ACCUM: in_ready=1. On accept, compare in_data against the registered max/min/prev (rules below), count++, prev=in_data. When the accepted sample makes count==WIN_LEN, go to REPORT on that same edge.
  - REPORT: in_ready=0, out_valid=1. Outputs are held stable until the handshake. On out_valid && out_ready, go to IDLE with out_valid=0 on the next cycle.
- Comparison rules: instantiate three `comparator` sub-modules, all with A=in_data.
  - B=max: a_bigger → max<=in_data.
  - B=min: b_bigger → min<=in_data.
  - B=prev: equals → eq_cnt++.
  - Ties leave max/min unchanged.
- Latency:
  - Outputs update on the edge that accepts the WIN_LEN-th sample.
  - out_valid is high from the cycle after that edge.
  - Minimum REPORT dwell is 1 cycle, even if out_ready is already high.
  - in_ready is low for every REPORT cycle.
- Stalls: with in_valid low, no state changes. Gaps between samples are allowed in any number.
- Boundary conditions:
  - WIN_LEN==1: max=min=sample, eq_cnt=0.
  - All samples equal: eq_cnt=WIN_LEN-1.
  - Values 0 and 15 are handled without wrap.
  - eq_cnt never exceeds WIN_LEN-1, so it cannot overflow CNT_W.
- Reset mid-operation: rst in any state discards the partial window and any unaccepted result. rst has priority over a simultaneous accept or handshake.
- Output registers: out_max/out_min/out_eq_cnt are driven from the working registers and are only guaranteed meaningful while out_valid=1.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE=2'd0, ACCUM=2'd1, REPORT=2'd2;
  - SAMPLE_W=4.
- Sub-module: the existing `comparator`, instantiated three times with bit-level port hookup (a0..a3, b0..b3).
- No other sub-module.

Test Plan:
- Reset behaviour: assert rst for 2 cycles with in_valid=1 → in_ready=1, out_valid=0, all outputs 0.
- Basic window: WIN_LEN=8, samples 3,7,7,0,15,15,15,2 back-to-back, out_ready=1 → out_valid for 1 cycle with max=15, min=0, eq_cnt=3; in_ready low in that cycle.
- Output backpressure: same window with out_ready=0 for 5 cycles → outputs held stable and in_ready=0 throughout; result accepted on the first out_ready=1 cycle; IDLE next cycle.
- Input gaps and all-equal window: samples 9 x8 with in_valid toggling 1,0 → max=min=9, eq_cnt=7; count advances only on accepted cycles.
- Reset mid-window: send 4 samples (12,1,5,5), assert rst, then send 8 samples of 6 → result max=min=6, eq_cnt=7, with no contamination from 12 or 1.
- Parameter edge: WIN_LEN=1, send 10 → out_valid with max=min=10, eq_cnt=0. Also check exhaustively that every (prev, sample) pair 0..15 × 0..15 yields correct max/min/eq updates.
